// File: rtl/reg_slice_backward.sv
// Ready-path register slice: s_rdy comes from a flop, while vld/pld bypass
// combinationally whenever the in-order skid buffer is empty.
module reg_slice_backward #(
  parameter type PLD_TYPE = logic,
  parameter int SKID_DEPTH = 1,
  localparam int CW = $clog2(SKID_DEPTH + 1),
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_vld,
  output logic          s_rdy,
  input  PLD_TYPE       s_pld,
  output logic          m_vld,
  input  logic          m_rdy,
  output PLD_TYPE       m_pld,
  output logic [CW-1:0] occupancy
);

  PLD_TYPE       mem_q [SKID_DEPTH];
  PLD_TYPE       mem_d [SKID_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q, rdy_d;
  logic          empty, acc, push, pop;

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty = (count_q == '0);
    acc   = s_vld & rdy_q;
    // Once anything is queued, new beats must queue behind it to keep order.
    push  = acc & (~empty | ~m_rdy);
    pop   = ~empty & m_rdy;
    m_vld = empty ? s_vld : 1'b1;
    m_pld = empty ? s_pld : mem_q[rd_ptr_q];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_pld;
      wr_ptr_d        = adv(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = adv(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    rdy_d = (int'(count_d) < SKID_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b1;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign s_rdy     = rdy_q;
  assign occupancy = count_q;

endmodule

// File: tb/tb_reg_slice_backward.sv
// Bench for reg_slice_backward: depth-1 and depth-3 instances, scoreboard
// monitors per instance plus scenario tasks with inline checks.
module tb_reg_slice_backward;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_vec = 0;
  int         n_err = 0;

  logic       s_vld1, s_rdy1, m_vld1, m_rdy1;
  logic [7:0] s_pld1, m_pld1;
  logic [0:0] occ1;
  logic       s_vld3, s_rdy3, m_vld3, m_rdy3;
  logic [7:0] s_pld3, m_pld3;
  logic [1:0] occ3;

  logic [7:0] q1[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  reg_slice_backward #(.PLD_TYPE(logic [7:0]), .SKID_DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .s_vld(s_vld1), .s_rdy(s_rdy1), .s_pld(s_pld1),
    .m_vld(m_vld1), .m_rdy(m_rdy1), .m_pld(m_pld1),
    .occupancy(occ1)
  );

  reg_slice_backward #(.PLD_TYPE(logic [7:0]), .SKID_DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .s_vld(s_vld3), .s_rdy(s_rdy3), .s_pld(s_pld3),
    .m_vld(m_vld3), .m_rdy(m_rdy3), .m_pld(m_pld3),
    .occupancy(occ3)
  );

  // Scoreboard and invariants for the depth-1 instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_vld1 && s_rdy1) q1.push_back(s_pld1);
      if (m_vld1 && m_rdy1) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL sb1_extra: got %h, required nothing", m_pld1);
        end else begin
          automatic logic [7:0] e = q1.pop_front();
          if (m_pld1 !== e) begin
            n_err++;
            $display("FAIL sb1_order: got %h, required %h", m_pld1, e);
          end
        end
      end
      if (occ1 > 1 || (occ1 == 1 && s_rdy1) || (occ1 != 0 && !m_vld1)) begin
        n_err++;
        $display("FAIL inv1: occ %0d s_rdy %b m_vld %b", occ1, s_rdy1, m_vld1);
      end
    end
  end

  // Scoreboard and invariants for the depth-3 instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_vld3 && s_rdy3) q3.push_back(s_pld3);
      if (m_vld3 && m_rdy3) begin
        n_vec++;
        if (q3.size() == 0) begin
          n_err++;
          $display("FAIL sb3_extra: got %h, required nothing", m_pld3);
        end else begin
          automatic logic [7:0] e = q3.pop_front();
          if (m_pld3 !== e) begin
            n_err++;
            $display("FAIL sb3_order: got %h, required %h", m_pld3, e);
          end
        end
      end
      if (occ3 > 3 || (occ3 == 3 && s_rdy3) || (occ3 != 0 && !m_vld3)) begin
        n_err++;
        $display("FAIL inv3: occ %0d s_rdy %b m_vld %b", occ3, s_rdy3, m_vld3);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_vld1 = 0; s_pld1 = 0; m_rdy1 = 1;
    s_vld3 = 0; s_pld3 = 0; m_rdy3 = 1;
    rst_n = 0;
    next_cyc();
    rst_n = 1;
    q1.delete();
    q3.delete();
    @(negedge clk);
    n_vec++;
    if (s_rdy3 !== 1'b1 || occ3 !== 2'd0 || m_vld3 !== 1'b0) begin
      n_err++;
      $display("FAIL reset3: s_rdy %b occ %0d m_vld %b, required 1 0 0",
               s_rdy3, occ3, m_vld3);
    end
    n_vec++;
    if (s_rdy1 !== 1'b1 || occ1 !== 1'd0 || m_vld1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset1: s_rdy %b occ %0d m_vld %b, required 1 0 0",
               s_rdy1, occ1, m_vld1);
    end
    next_cyc();
  endtask

  task automatic test_bypass();
    m_rdy3 = 1;
    for (int i = 1; i <= 8; i++) begin
      s_vld3 = 1;
      s_pld3 = 8'(i);
      @(negedge clk);
      n_vec++;
      if (m_vld3 !== 1'b1 || m_pld3 !== 8'(i) || occ3 !== 2'd0 || s_rdy3 !== 1'b1) begin
        n_err++;
        $display("FAIL bypass: m_vld %b m_pld %h occ %0d s_rdy %b, required 1 %h 0 1",
                 m_vld3, m_pld3, occ3, s_rdy3, 8'(i));
      end
      next_cyc();
    end
    s_vld3 = 0;
    next_cyc();
  endtask

  task automatic test_depth1();
    s_vld1 = 1; s_pld1 = 8'hA1; m_rdy1 = 0;
    next_cyc();
    s_pld1 = 8'hA2;
    @(negedge clk);
    n_vec++;
    if (occ1 !== 1'd1 || s_rdy1 !== 1'b0 || m_vld1 !== 1'b1 || m_pld1 !== 8'hA1) begin
      n_err++;
      $display("FAIL d1_full: occ %0d s_rdy %b m_vld %b m_pld %h, required 1 0 1 a1",
               occ1, s_rdy1, m_vld1, m_pld1);
    end
    next_cyc();
    m_rdy1 = 1;
    @(negedge clk);
    n_vec++;
    if (m_pld1 !== 8'hA1 || s_rdy1 !== 1'b0) begin
      n_err++;
      $display("FAIL d1_drain: m_pld %h s_rdy %b, required a1 0", m_pld1, s_rdy1);
    end
    next_cyc();
    @(negedge clk);
    n_vec++;
    if (s_rdy1 !== 1'b1 || occ1 !== 1'd0 || m_pld1 !== 8'hA2) begin
      n_err++;
      $display("FAIL d1_refill: s_rdy %b occ %0d m_pld %h, required 1 0 a2",
               s_rdy1, occ1, m_pld1);
    end
    next_cyc();
    s_vld1 = 0;
    next_cyc();
  endtask

  task automatic test_fill3();
    m_rdy3 = 0;
    for (int i = 0; i < 3; i++) begin
      s_vld3 = 1;
      s_pld3 = 8'h10 + 8'(i);
      @(negedge clk);
      n_vec++;
      if (occ3 !== 2'(i) || s_rdy3 !== 1'b1) begin
        n_err++;
        $display("FAIL fill3_occ: occ %0d s_rdy %b, required %0d 1", occ3, s_rdy3, i);
      end
      next_cyc();
    end
    s_vld3 = 0;
    @(negedge clk);
    n_vec++;
    if (occ3 !== 2'd3 || s_rdy3 !== 1'b0 || m_pld3 !== 8'h10) begin
      n_err++;
      $display("FAIL fill3_full: occ %0d s_rdy %b head %h, required 3 0 10",
               occ3, s_rdy3, m_pld3);
    end
    next_cyc();
    m_rdy3 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (m_vld3 !== 1'b1 || m_pld3 !== 8'h10 + 8'(i)) begin
        n_err++;
        $display("FAIL fill3_drain: m_vld %b m_pld %h, required 1 %h",
                 m_vld3, m_pld3, 8'h10 + 8'(i));
      end
      next_cyc();
    end
    @(negedge clk);
    n_vec++;
    if (occ3 !== 2'd0 || s_rdy3 !== 1'b1) begin
      n_err++;
      $display("FAIL fill3_empty: occ %0d s_rdy %b, required 0 1", occ3, s_rdy3);
    end
    next_cyc();
  endtask

  task automatic test_push_pop();
    m_rdy3 = 0;
    for (int i = 0; i < 2; i++) begin
      s_vld3 = 1;
      s_pld3 = 8'h20 + 8'(i);
      next_cyc();
    end
    s_pld3 = 8'h22;
    m_rdy3 = 1;
    @(negedge clk);
    n_vec++;
    if (occ3 !== 2'd2 || m_pld3 !== 8'h20) begin
      n_err++;
      $display("FAIL pp_before: occ %0d head %h, required 2 20", occ3, m_pld3);
    end
    next_cyc();
    s_vld3 = 0;
    m_rdy3 = 0;
    @(negedge clk);
    n_vec++;
    if (occ3 !== 2'd2 || s_rdy3 !== 1'b1 || m_pld3 !== 8'h21) begin
      n_err++;
      $display("FAIL pp_after: occ %0d s_rdy %b head %h, required 2 1 21",
               occ3, s_rdy3, m_pld3);
    end
    next_cyc();
    m_rdy3 = 1;
    for (int i = 0; i < 4; i++) next_cyc();
  endtask

  task automatic test_random();
    int         beats = 0;
    int         cyc = 0;
    logic [7:0] pld = 8'h00;
    while (beats < 1000 && cyc < 5000) begin
      s_vld3 = 1;
      s_pld3 = pld;
      m_rdy3 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_rdy3) begin
        pld++;
        beats++;
      end
      next_cyc();
      cyc++;
    end
    n_vec++;
    if (beats != 1000) begin
      n_err++;
      $display("FAIL rand_budget: accepted %0d, required 1000", beats);
    end
    s_vld3 = 0;
    m_rdy3 = 1;
    for (int i = 0; i < 10 && q3.size() != 0; i++) next_cyc();
    @(negedge clk);
    n_vec++;
    if (q3.size() != 0 || occ3 !== 2'd0) begin
      n_err++;
      $display("FAIL rand_drain: left %0d occ %0d, required 0 0", q3.size(), occ3);
    end
    next_cyc();
  endtask

  task automatic test_reset_mid();
    m_rdy3 = 0;
    for (int i = 0; i < 2; i++) begin
      s_vld3 = 1;
      s_pld3 = 8'h30 + 8'(i);
      next_cyc();
    end
    s_vld3 = 0;
    @(negedge clk);
    n_vec++;
    if (occ3 !== 2'd2) begin
      n_err++;
      $display("FAIL rm_pre: occ %0d, required 2", occ3);
    end
    rst_n = 0;
    next_cyc();
    rst_n = 1;
    q3.delete();
    q1.delete();
    @(negedge clk);
    n_vec++;
    if (occ3 !== 2'd0 || s_rdy3 !== 1'b1 || m_vld3 !== 1'b0) begin
      n_err++;
      $display("FAIL rm_post: occ %0d s_rdy %b m_vld %b, required 0 1 0",
               occ3, s_rdy3, m_vld3);
    end
    next_cyc();
    s_vld3 = 1;
    s_pld3 = 8'h40;
    m_rdy3 = 1;
    @(negedge clk);
    n_vec++;
    if (m_vld3 !== 1'b1 || m_pld3 !== 8'h40) begin
      n_err++;
      $display("FAIL rm_fresh: m_vld %b m_pld %h, required 1 40", m_vld3, m_pld3);
    end
    next_cyc();
    s_vld3 = 0;
    for (int i = 0; i < 3; i++) next_cyc();
    n_vec++;
    if (q3.size() != 0) begin
      n_err++;
      $display("FAIL rm_stale: %0d beats left, required 0", q3.size());
    end
  endtask

  initial begin
    rst_n = 0;
    test_reset();
    test_bypass();
    test_depth1();
    test_fill3();
    test_push_pop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_slice_backward.md
Name: reg_slice_backward

Overview:
- Ready-path register slice: breaks the combinational m_rdy -> s_rdy timing path of a valid/ready/payload channel.
- It is the counterpart of the forward slice, which registers vld/pld. Here s_rdy is a flop, and vld/pld pass combinationally when the slice is empty.
- A SKID_DEPTH-entry in-order skid buffer absorbs beats accepted while downstream stalls.
- Placed on long ready-return routes between pipeline stages; chained with the forward slice to form a full slice.

Parameters:
- PLD_TYPE, logic, payload type; width W = $bits(PLD_TYPE).
- SKID_DEPTH, 1, skid entries; legal range is 1 to 16, not restricted to powers of two.
- CW, $clog2(SKID_DEPTH+1), occupancy width (derived).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset: one clock, synchronous, active-low.
- s_vld  input  1  upstream valid.
- s_rdy  output  1  upstream ready; driven directly from a flop.
- s_pld  input  W  upstream payload.
- m_vld  output  1  downstream valid.
- m_rdy  input  1  downstream ready.
- m_pld  output  W  downstream payload.
- occupancy  output  CW  number of skid entries held; driven from a flop.

Behaviour:
- State:
  - buf[SKID_DEPTH] of PLD_TYPE.
  - wr_ptr and rd_ptr, each $clog2(SKID_DEPTH) bits, minimum 1.
  - count (CW bits).
  - rdy_r.
- Reset (rst_n low at a posedge):
  - count=0, wr_ptr=0, rd_ptr=0, rdy_r=1, buf entries = 0.
  - After reset: s_rdy=1, occupancy=0. m_vld equals s_vld because the slice is empty.
  - Reset mid-operation discards all buffered beats, with no drain.
- s_rdy = rdy_r. No combinational path from m_rdy or s_vld to s_rdy.
- acc = s_vld && s_rdy.
- Empty (count==0), bypass mode:
  - m_vld = s_vld, m_pld = s_pld. Zero latency.
  - acc && m_rdy: beat passes through; no buffer write.
  - acc && !m_rdy: write s_pld to buf[wr_ptr]; wr_ptr advances; count becomes 1.
- Non-empty (count>0):
  - m_vld = 1, m_pld = buf[rd_ptr].
  - pop = m_rdy: rd_ptr advances, count decrements.
  - push = acc: the input beat always enters the buffer, never bypasses, so order is preserved. wr_ptr advances, count increments.
  - push && pop in the same cycle: count unchanged, both pointers advance.
- Pointer wrap: a pointer advances to (ptr == SKID_DEPTH-1) ? 0 : ptr+1.
- rdy_r <= (count_next < SKID_DEPTH), evaluated every non-reset cycle.
  - Consequence: s_rdy drops the cycle after the buffer fills.
  - It rises the cycle after the first pop from a full buffer, i.e. one bubble of ready latency.
- Full (count==SKID_DEPTH): s_rdy=0; s_vld is ignored and s_pld need not be held stable for the slice.
- occupancy = count.
- Assertions (bench side):
  - count never exceeds SKID_DEPTH.
  - No write while count==SKID_DEPTH.
  - m_vld is never low while count>0.
- Throughput:
  - Full rate sustained when m_rdy stays high.
  - With m_rdy toggling, no beat is lost or duplicated and order is strictly FIFO.
- Upstream protocol:
  - s_vld may assert independently of s_rdy.
  - Once asserted, s_vld/s_pld are held until acc.
  - Downstream sees the same guarantee on m_vld/m_pld.

Test Plan:
- Reset, then s_vld=1, m_rdy=1, payloads 0x01..0x08 back-to-back → m_pld shows 0x01..0x08 in the same cycles (bypass); occupancy stays 0; s_rdy stays 1.
- SKID_DEPTH=1: send 0xA1 with m_rdy=0 → next cycle occupancy=1, s_rdy=0, m_vld=1, m_pld=0xA1. Hold 0xA2 on s_pld; raise m_rdy → 0xA1 drains; s_rdy=1 one cycle later; then 0xA2 is accepted.
- SKID_DEPTH=3, m_rdy=0, stream 0x10,0x11,0x12 → occupancy 1,2,3; s_rdy=0 after the third beat. Then m_rdy=1 → output 0x10,0x11,0x12 in order.
- SKID_DEPTH=3, continuous input with random m_rdy (about 50%) for 1000 beats → scoreboard shows exact in-order delivery; pointers wrap cleanly at index 2; no drop or duplicate.
- Simultaneous push/pop at count=2: s_vld=1, m_rdy=1 → count stays 2, s_rdy stays 1, head advances one entry.
- Assert rst_n=0 for one cycle with occupancy=2 → next cycle occupancy=0, s_rdy=1, m_vld equals s_vld; stale beats never appear on m_pld.
